turn_controller: RTL and testbench
==================================

# turn_controller

Turn sequencer for the Yacht Dice game: owns the per-player turn state machine that drives the dice block's roll, roll-count and clear inputs. It converts debounced button levels into a timed roll burst, enforces the three-roll limit and the first-roll hold rule, and gates category commits to the scoreboard. It advances player and round, and flags game over. It sits between board I/O (buttons, DIP switches) and the dice manager and scoreboard.

## Interface
- NUM_PLAYERS, 2: players in rotation (2..4).
- ROLL_CYCLES, 16: cycles `roll_en` stays high per roll (≥1); the dice re-sample every cycle, producing the tumble.
- NUM_ROUNDS, 12: rounds per game (one per category).
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- roll_btn  input  1  debounced, synchronized level; the action is its rising edge.
- confirm_btn  input  1  debounced, synchronized level; the action is its rising edge.
- hold_sw  input  5  hold switches, same as those wired to the dice block.
- cat_sel  input  4  category chosen for commit (0..11 valid).
- cat_used  input  12  categories already filled for the current player, from the scoreboard.
- roll_en  output  1  to the dice block; high for the full roll burst.
- roll_cnt  output  2  completed rolls this turn (0..3), to the dice block.
- dice_clear  output  1  one-cycle pulse at the start of each turn.
- score_commit  output  1  one-cycle pulse; the scoreboard latches `commit_cat` for `player`.
- commit_cat  output  4  registered `cat_sel` at commit.
- player  output  2  current player index.
- round  output  4  current round (0-based).
- roll_reject  output  1  one-cycle pulse when a roll request is refused.
- game_over  output  1  level; high once all rounds are complete.

## Operation
- States: TURN_START, WAIT_ROLL, ROLLING, ROLLED, COMMIT, NEXT, GAME_OVER.
- Edge detect: register each button; an edge is `btn & ~btn_q`. Edges are ignored in all states except WAIT_ROLL and ROLLED.
- TURN_START: assert `dice_clear`, clear `roll_cnt` to 0, then go to WAIT_ROLL.
- WAIT_ROLL (roll_cnt = 0), roll edge:
  - With `|hold_sw` = 0: go to ROLLING.
  - With `|hold_sw` ≠ 0: pulse `roll_reject` and stay in WAIT_ROLL.
  - Confirm edges are ignored.
- ROLLING: `roll_en` = 1. The burst counter counts ROLL_CYCLES cycles. On the last cycle, `roll_cnt` increments and the state goes to ROLLED. `roll_cnt` holds its pre-roll value throughout the burst.
- ROLLED, confirm edge:
  - If `cat_sel` < 12 and `cat_used[cat_sel]` = 0: latch `commit_cat` and go to COMMIT.
  - Otherwise pulse `roll_reject` and stay.
- ROLLED, roll edge:
  - If `roll_cnt` < 3: go to ROLLING. Holds are permitted.
  - If `roll_cnt` = 3: pulse `roll_reject` and stay.
- Simultaneous roll and confirm edges: a legal confirm wins and the roll is dropped. An illegal confirm means the roll is evaluated instead, with at most one `roll_reject` pulse.
- COMMIT: pulse `score_commit` for one cycle, then go to NEXT.
- NEXT: `player` increments.
  - When it wraps from NUM_PLAYERS−1 to 0, `round` increments.
  - If the new `round` = NUM_ROUNDS: go to GAME_OVER.
  - Otherwise go to TURN_START.
- GAME_OVER: `game_over` = 1, all buttons are ignored, and the block exits only on reset. `round` holds NUM_ROUNDS.
- Reset, including mid-burst: the state goes to TURN_START. `roll_en`, `score_commit`, `roll_reject` and `game_over` = 0; `roll_cnt`, `player`, `round` and `commit_cat` = 0; button history registers = 0.

## Timing
- Roll edge sampled at cycle t: `roll_en` is high for cycles t+1..t+ROLL_CYCLES. `roll_cnt`+1 is visible from t+ROLL_CYCLES+1.
- Confirm edge at t: `score_commit` is high at t+1, the player and round update at t+2, and `dice_clear` is high at t+3.
- The first cycle after `reset` deasserts has `dice_clear` = 1.
- All outputs are registered. No combinational path runs from inputs to outputs.
- `hold_sw` and `cat_sel` are sampled only on the edge cycle. Changing `hold_sw` mid-burst affects the dice block only.

## Structure
- Shared package `yacht_pkg`:
  - state enum;
  - NUM_CATEGORIES = 12;
  - MAX_ROLLS = 3;
  - category index width (4).
  - The scoreboard imports the same constants.
- Sub-module `edge_pulse` (1-bit registered rising-edge detector), instantiated once per button.
- The burst counter width is `$clog2(ROLL_CYCLES+1)`.

## Test plan
- Reset, then roll edge with `hold_sw` = 0, ROLL_CYCLES = 4: `dice_clear` is high on cycle 1 only, `roll_en` is high for exactly 4 cycles, and `roll_cnt` goes 0→1 after the burst.
- First roll with `hold_sw` = 5'b00010: `roll_reject` pulses once, `roll_en` stays 0, and the state stays in WAIT_ROLL.
- Three rolls, then a fourth roll edge: the fourth gives `roll_reject`, no `roll_en`, and `roll_cnt` stays 3.
- Confirm with `cat_sel` = 5 and `cat_used[5]` = 1: `roll_reject`. Then `cat_sel` = 6 (unused): `score_commit` fires once with `commit_cat` = 6, `player` goes 0→1, and `dice_clear` follows.
- Play 2 players × 12 rounds of commits: `game_over` rises after the 24th commit, and further edges produce no outputs.
- Assert `reset` during cycle 2 of a burst: `roll_en` drops on the next cycle and all outputs return to their reset values.

Source files
------------

// File: rtl/yacht_pkg.sv
// Shared Yacht Dice constants and the turn-sequencer state encoding.
// The scoreboard imports the same category constants.
package yacht_pkg;

  localparam int NUM_CATEGORIES = 12;
  localparam int MAX_ROLLS      = 3;
  localparam int CAT_W          = 4;

  typedef enum logic [2:0] {
    TURN_START,
    WAIT_ROLL,
    ROLLING,
    ROLLED,
    COMMIT,
    NEXT,
    GAME_OVER
  } turn_state_t;

  // Indices past the last category read as "used", so out-of-range selects are refused.
  function automatic logic cat_open(input logic [CAT_W-1:0]          cat,
                                    input logic [NUM_CATEGORIES-1:0] used);
    logic [2**CAT_W-1:0] ext;
    ext = {{(2**CAT_W - NUM_CATEGORIES){1'b1}}, used};
    return ~ext[cat];
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for one debounced, synchronized button level.
// The history bit is registered; the pulse is high for the cycle the level first reads 1.
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/turn_controller.sv
// Yacht Dice turn sequencer: timed roll bursts, three-roll limit, first-roll hold rule,
// gated category commits, and player/round rotation up to game over.
//
// state      | meaning
// TURN_START | dice_clear high, roll count cleared
// WAIT_ROLL  | no roll yet this turn; holds not allowed
// ROLLING    | roll_en burst, down-counter to terminal count
// ROLLED     | at least one roll done; roll again or commit
// COMMIT     | score_commit pulse, player/round advance
// NEXT       | decide next turn or end of game
// GAME_OVER  | terminal until reset
module turn_controller
  import yacht_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int ROLL_CYCLES = 16,
  parameter int NUM_ROUNDS  = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      roll_btn,
  input  logic                      confirm_btn,
  input  logic [4:0]                hold_sw,
  input  logic [CAT_W-1:0]          cat_sel,
  input  logic [NUM_CATEGORIES-1:0] cat_used,
  output logic                      roll_en,
  output logic [1:0]                roll_cnt,
  output logic                      dice_clear,
  output logic                      score_commit,
  output logic [CAT_W-1:0]          commit_cat,
  output logic [1:0]                player,
  output logic [3:0]                round,
  output logic                      roll_reject,
  output logic                      game_over
);

  localparam int BW = $clog2(ROLL_CYCLES + 1);
  localparam logic [BW-1:0] BURST_LOAD  = BW'(ROLL_CYCLES);
  localparam logic [BW-1:0] BURST_LAST  = BW'(1);
  localparam logic [1:0]    ROLL_LIMIT  = 2'(MAX_ROLLS);
  localparam logic [1:0]    LAST_PLAYER = 2'(NUM_PLAYERS - 1);
  localparam logic [3:0]    ROUND_END   = 4'(NUM_ROUNDS);

  turn_state_t   state;
  logic [BW-1:0] burst;
  logic          roll_edge;
  logic          confirm_edge;

  edge_pulse u_roll_edge (
    .clk   (clk),
    .reset (reset),
    .level (roll_btn),
    .pulse (roll_edge)
  );

  edge_pulse u_confirm_edge (
    .clk   (clk),
    .reset (reset),
    .level (confirm_btn),
    .pulse (confirm_edge)
  );

  // dice_clear resets high so the first cycle out of reset clears the dice.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= TURN_START;
      burst        <= '0;
      roll_en      <= 1'b0;
      roll_cnt     <= 2'd0;
      dice_clear   <= 1'b1;
      score_commit <= 1'b0;
      commit_cat   <= '0;
      player       <= 2'd0;
      round        <= 4'd0;
      roll_reject  <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      dice_clear   <= 1'b0;
      score_commit <= 1'b0;
      roll_reject  <= 1'b0;
      case (state)
        TURN_START: begin
          roll_cnt <= 2'd0;
          state    <= WAIT_ROLL;
        end
        WAIT_ROLL: begin
          if (roll_edge) begin
            if (|hold_sw) begin
              roll_reject <= 1'b1;
            end else begin
              roll_en <= 1'b1;
              burst   <= BURST_LOAD;
              state   <= ROLLING;
            end
          end
        end
        ROLLING: begin
          if (burst == BURST_LAST) begin
            roll_en  <= 1'b0;
            roll_cnt <= roll_cnt + 2'd1;
            state    <= ROLLED;
          end else begin
            burst <= burst - BURST_LAST;
          end
        end
        ROLLED: begin
          // A legal confirm beats a simultaneous roll; an illegal one defers to the roll.
          if (confirm_edge && cat_open(cat_sel, cat_used)) begin
            commit_cat   <= cat_sel;
            score_commit <= 1'b1;
            state        <= COMMIT;
          end else if (roll_edge) begin
            if (roll_cnt < ROLL_LIMIT) begin
              roll_en <= 1'b1;
              burst   <= BURST_LOAD;
              state   <= ROLLING;
            end else begin
              roll_reject <= 1'b1;
            end
          end else if (confirm_edge) begin
            roll_reject <= 1'b1;
          end
        end
        COMMIT: begin
          if (player == LAST_PLAYER) begin
            player <= 2'd0;
            round  <= round + 4'd1;
          end else begin
            player <= player + 2'd1;
          end
          state <= NEXT;
        end
        NEXT: begin
          if (round == ROUND_END) begin
            game_over <= 1'b1;
            state     <= GAME_OVER;
          end else begin
            dice_clear <= 1'b1;
            state      <= TURN_START;
          end
        end
        GAME_OVER: begin
          game_over <= 1'b1;
        end
        default: begin
          state <= TURN_START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller with ROLL_CYCLES = 4, two players, twelve rounds.
// Inputs change and outputs are observed 1 ns after each rising clock edge.
module tb_turn_controller;

  logic        clk;
  logic        reset;
  logic        roll_btn;
  logic        confirm_btn;
  logic [4:0]  hold_sw;
  logic [3:0]  cat_sel;
  logic [11:0] cat_used;
  logic        roll_en;
  logic [1:0]  roll_cnt;
  logic        dice_clear;
  logic        score_commit;
  logic [3:0]  commit_cat;
  logic [1:0]  player;
  logic [3:0]  round;
  logic        roll_reject;
  logic        game_over;

  int tests_run    = 0;
  int tests_failed = 0;

  // Per-press observation window results (index 0 = cycle after the sampling edge).
  int n_en, n_rej, n_com, n_clr;
  int i_en, i_cnt, i_com, i_ply, i_clr;

  turn_controller #(
    .NUM_PLAYERS (2),
    .ROLL_CYCLES (4),
    .NUM_ROUNDS  (12)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .roll_btn     (roll_btn),
    .confirm_btn  (confirm_btn),
    .hold_sw      (hold_sw),
    .cat_sel      (cat_sel),
    .cat_used     (cat_used),
    .roll_en      (roll_en),
    .roll_cnt     (roll_cnt),
    .dice_clear   (dice_clear),
    .score_commit (score_commit),
    .commit_cat   (commit_cat),
    .player       (player),
    .round        (round),
    .roll_reject  (roll_reject),
    .game_over    (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset, then step once so the FSM sits in WAIT_ROLL.
  task automatic do_reset;
    reset = 1'b1; roll_btn = 1'b0; confirm_btn = 1'b0;
    hold_sw = 5'd0; cat_sel = 4'd0; cat_used = 12'd0;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  // Pulse the buttons for one sampling edge, then watch 10 cycles.
  task automatic press(input logic r, input logic c);
    logic [1:0] p0;
    logic [1:0] k0;
    p0 = player; k0 = roll_cnt;
    n_en = 0; n_rej = 0; n_com = 0; n_clr = 0;
    i_en = -1; i_cnt = -1; i_com = -1; i_ply = -1; i_clr = -1;
    roll_btn = r; confirm_btn = c;
    tick;
    roll_btn = 1'b0; confirm_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (roll_en)      begin n_en++;  if (i_en  < 0) i_en  = i; end
      if (roll_reject)  n_rej++;
      if (score_commit) begin n_com++; if (i_com < 0) i_com = i; end
      if (dice_clear)   begin n_clr++; if (i_clr < 0) i_clr = i; end
      if (player   !== p0 && i_ply < 0) i_ply = i;
      if (roll_cnt !== k0 && i_cnt < 0) i_cnt = i;
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; roll_btn = 1'b0; confirm_btn = 1'b0;
    hold_sw = 5'd0; cat_sel = 4'd0; cat_used = 12'd0;
    tick; tick;
    tests_run++; if ({roll_en, score_commit, roll_reject, game_over} !== 4'b0000) begin tests_failed++; $display("FAIL reset_pulses: got %b expected 0000", {roll_en, score_commit, roll_reject, game_over}); end
    tests_run++; if ({roll_cnt, player, round, commit_cat} !== 12'd0) begin tests_failed++; $display("FAIL reset_regs: got %h expected 000", {roll_cnt, player, round, commit_cat}); end
    reset = 1'b0;
    tests_run++; if (dice_clear !== 1'b1) begin tests_failed++; $display("FAIL reset_first_clear: got %0d expected 1", dice_clear); end
    tick;
    tests_run++; if (dice_clear !== 1'b0) begin tests_failed++; $display("FAIL reset_clear_once: got %0d expected 0", dice_clear); end
  endtask

  task automatic test_first_roll;
    press(1'b1, 1'b0);
    tests_run++; if (n_en !== 4) begin tests_failed++; $display("FAIL roll_en_len: got %0d expected 4", n_en); end
    tests_run++; if (i_en !== 0) begin tests_failed++; $display("FAIL roll_en_start: got %0d expected 0", i_en); end
    tests_run++; if (i_cnt !== 4) begin tests_failed++; $display("FAIL roll_cnt_timing: got %0d expected 4", i_cnt); end
    tests_run++; if (roll_cnt !== 2'd1) begin tests_failed++; $display("FAIL roll_cnt_after: got %0d expected 1", roll_cnt); end
    tests_run++; if (n_rej !== 0) begin tests_failed++; $display("FAIL roll_no_reject: got %0d expected 0", n_rej); end
  endtask

  task automatic test_hold_reject;
    do_reset;
    hold_sw = 5'b00010;
    press(1'b1, 1'b0);
    tests_run++; if (n_rej !== 1) begin tests_failed++; $display("FAIL hold_reject_cnt: got %0d expected 1", n_rej); end
    tests_run++; if (n_en !== 0) begin tests_failed++; $display("FAIL hold_no_roll: got %0d expected 0", n_en); end
    tests_run++; if (roll_cnt !== 2'd0) begin tests_failed++; $display("FAIL hold_roll_cnt: got %0d expected 0", roll_cnt); end
    hold_sw = 5'd0;
    press(1'b1, 1'b0);
    tests_run++; if (n_en !== 4) begin tests_failed++; $display("FAIL hold_then_roll: got %0d expected 4", n_en); end
  endtask

  task automatic test_roll_limit;
    hold_sw = 5'b10101;
    press(1'b1, 1'b0);
    tests_run++; if (roll_cnt !== 2'd2 || n_en !== 4) begin tests_failed++; $display("FAIL limit_roll2: got cnt %0d en %0d expected cnt 2 en 4", roll_cnt, n_en); end
    press(1'b1, 1'b0);
    tests_run++; if (roll_cnt !== 2'd3 || n_en !== 4) begin tests_failed++; $display("FAIL limit_roll3: got cnt %0d en %0d expected cnt 3 en 4", roll_cnt, n_en); end
    press(1'b1, 1'b0);
    tests_run++; if (n_rej !== 1) begin tests_failed++; $display("FAIL limit_reject: got %0d expected 1", n_rej); end
    tests_run++; if (n_en !== 0) begin tests_failed++; $display("FAIL limit_no_roll: got %0d expected 0", n_en); end
    tests_run++; if (roll_cnt !== 2'd3) begin tests_failed++; $display("FAIL limit_cnt_held: got %0d expected 3", roll_cnt); end
    hold_sw = 5'd0;
  endtask

  task automatic test_confirm;
    cat_used = 12'h020;
    cat_sel  = 4'd5;
    press(1'b0, 1'b1);
    tests_run++; if (n_rej !== 1) begin tests_failed++; $display("FAIL used_cat_reject: got %0d expected 1", n_rej); end
    tests_run++; if (n_com !== 0) begin tests_failed++; $display("FAIL used_cat_no_commit: got %0d expected 0", n_com); end
    cat_sel = 4'd6;
    press(1'b0, 1'b1);
    tests_run++; if (n_com !== 1 || i_com !== 0) begin tests_failed++; $display("FAIL commit_pulse: got n %0d at %0d expected n 1 at 0", n_com, i_com); end
    tests_run++; if (commit_cat !== 4'd6) begin tests_failed++; $display("FAIL commit_cat: got %0d expected 6", commit_cat); end
    tests_run++; if (player !== 2'd1 || i_ply !== 1) begin tests_failed++; $display("FAIL commit_player: got %0d at %0d expected 1 at 1", player, i_ply); end
    tests_run++; if (n_clr !== 1 || i_clr !== 2) begin tests_failed++; $display("FAIL commit_clear: got n %0d at %0d expected n 1 at 2", n_clr, i_clr); end
    tests_run++; if (roll_cnt !== 2'd0 || round !== 4'd0) begin tests_failed++; $display("FAIL commit_newturn: got cnt %0d round %0d expected 0 0", roll_cnt, round); end
  endtask

  task automatic test_simultaneous;
    press(1'b1, 1'b0);
    cat_sel = 4'd12;
    press(1'b1, 1'b1);
    tests_run++; if (n_en !== 4 || n_com !== 0 || n_rej !== 0) begin tests_failed++; $display("FAIL simul_illegal_roll: got en %0d com %0d rej %0d expected 4 0 0", n_en, n_com, n_rej); end
    tests_run++; if (roll_cnt !== 2'd2) begin tests_failed++; $display("FAIL simul_cnt: got %0d expected 2", roll_cnt); end
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    tests_run++; if (n_rej !== 1 || n_en !== 0) begin tests_failed++; $display("FAIL simul_single_reject: got rej %0d en %0d expected 1 0", n_rej, n_en); end
    cat_sel = 4'd0; cat_used = 12'd0;
    press(1'b1, 1'b1);
    tests_run++; if (n_com !== 1 || n_en !== 0) begin tests_failed++; $display("FAIL simul_legal_wins: got com %0d en %0d expected 1 0", n_com, n_en); end
    tests_run++; if (player !== 2'd0 || round !== 4'd1) begin tests_failed++; $display("FAIL simul_wrap: got player %0d round %0d expected 0 1", player, round); end
  endtask

  task automatic test_game_over;
    int commits;
    commits = 0;
    do_reset;
    for (int k = 0; k < 24; k++) begin
      press(1'b1, 1'b0);
      cat_sel = 4'(k / 2);
      press(1'b0, 1'b1);
      commits += n_com;
      if (k == 22) begin
        tests_run++; if (game_over !== 1'b0 || round !== 4'd11 || player !== 2'd1) begin tests_failed++; $display("FAIL go_before_last: got go %0d round %0d player %0d expected 0 11 1", game_over, round, player); end
      end
    end
    tests_run++; if (commits !== 24) begin tests_failed++; $display("FAIL go_commits: got %0d expected 24", commits); end
    tests_run++; if (n_clr !== 0) begin tests_failed++; $display("FAIL go_no_clear: got %0d expected 0", n_clr); end
    tests_run++; if (game_over !== 1'b1 || round !== 4'd12 || player !== 2'd0) begin tests_failed++; $display("FAIL go_state: got go %0d round %0d player %0d expected 1 12 0", game_over, round, player); end
    press(1'b1, 1'b0);
    tests_run++; if (n_en !== 0 || n_rej !== 0) begin tests_failed++; $display("FAIL go_roll_ignored: got en %0d rej %0d expected 0 0", n_en, n_rej); end
    press(1'b0, 1'b1);
    tests_run++; if (n_com !== 0 || n_rej !== 0 || n_clr !== 0) begin tests_failed++; $display("FAIL go_confirm_ignored: got com %0d rej %0d clr %0d expected 0 0 0", n_com, n_rej, n_clr); end
    tests_run++; if (game_over !== 1'b1 || round !== 4'd12) begin tests_failed++; $display("FAIL go_held: got go %0d round %0d expected 1 12", game_over, round); end
  endtask

  task automatic test_reset_mid_burst;
    do_reset;
    tests_run++; if (game_over !== 1'b0) begin tests_failed++; $display("FAIL rst_clears_go: got %0d expected 0", game_over); end
    cat_sel = 4'd7;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    tests_run++; if (player !== 2'd1 || commit_cat !== 4'd7) begin tests_failed++; $display("FAIL mid_setup: got player %0d cat %0d expected 1 7", player, commit_cat); end
    roll_btn = 1'b1;
    tick;
    roll_btn = 1'b0;
    tick;
    tests_run++; if (roll_en !== 1'b1) begin tests_failed++; $display("FAIL mid_in_burst: got %0d expected 1", roll_en); end
    reset = 1'b1;
    tick;
    tests_run++; if (roll_en !== 1'b0) begin tests_failed++; $display("FAIL mid_roll_en_drop: got %0d expected 0", roll_en); end
    tests_run++; if ({roll_cnt, player, round, commit_cat} !== 12'd0) begin tests_failed++; $display("FAIL mid_regs: got %h expected 000", {roll_cnt, player, round, commit_cat}); end
    tests_run++; if ({score_commit, roll_reject, game_over} !== 3'b000) begin tests_failed++; $display("FAIL mid_pulses: got %b expected 000", {score_commit, roll_reject, game_over}); end
    reset = 1'b0;
    tests_run++; if (dice_clear !== 1'b1) begin tests_failed++; $display("FAIL mid_first_clear: got %0d expected 1", dice_clear); end
    tick;
    tests_run++; if (roll_en !== 1'b0 || roll_cnt !== 2'd0) begin tests_failed++; $display("FAIL mid_after: got en %0d cnt %0d expected 0 0", roll_en, roll_cnt); end
  endtask

  initial begin
    test_reset;
    test_first_roll;
    test_hold_reject;
    test_roll_limit;
    test_confirm;
    test_simultaneous;
    test_game_over;
    test_reset_mid_burst;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
